// File: rtl/vmon_msg_arb_pkg.sv
// Shared types and the round-robin scan used by the mailbox message arbiter.
package vmon_msg_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Widest requester vector the scan supports.
  localparam int RR_MAX = 16;

  // First set bit of valid scanning upward from ptr+1. Unused upper bits of
  // valid are zero, so wrapping modulo 16 behaves exactly like modulo N_REQ.
  // Returns ptr unchanged when nothing is valid.
  function automatic logic [3:0] rr_next(input logic [RR_MAX-1:0] valid,
                                         input logic [3:0]        ptr);
    logic [3:0] win;
    logic [3:0] idx;
    logic       found;
    win   = ptr;
    found = 1'b0;
    for (int k = 1; k <= RR_MAX; k++) begin
      idx = ptr + 4'(k);
      if (!found && valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/vmon_rr_arbiter.sv
// Round-robin pointer and winner select; the pointer moves only on update_i.
module vmon_rr_arbiter
  import vmon_msg_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         valid_i,
  input  logic                     update_i,
  input  logic [$clog2(N_REQ)-1:0] update_id_i,
  output logic [$clog2(N_REQ)-1:0] sel_o,
  output logic                     any_o
);

  localparam int GW = $clog2(N_REQ);

  logic [GW-1:0]     ptr_q;
  logic [RR_MAX-1:0] valid_ext;
  logic [3:0]        win;

  // Pointer starts at the top so requester 0 wins the first arbitration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= GW'(N_REQ - 1);
    end else if (update_i) begin
      ptr_q <= update_id_i;
    end
  end

  // Scan from the requester after the last grantee.
  always_comb begin
    valid_ext              = '0;
    valid_ext[N_REQ-1:0]   = valid_i;
    win                    = rr_next(valid_ext, 4'(ptr_q));
    sel_o                  = win[GW-1:0];
    any_o                  = |valid_i;
  end

endmodule

// File: rtl/vmon_msg_arbiter.sv
// Mailbox write-port arbiter: round-robin grant locked for a whole message,
// accepted beats replayed as registered single-cycle writes to ADDR.
// Optional forced release of a stalled grantee: VMON_MSG_ARB_TIMEOUT_EN.
module vmon_msg_arbiter
  import vmon_msg_arb_pkg::*;
#(
  parameter int                    N_REQ      = 4,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR       = '0,
  parameter int                    TIMEOUT    = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_REQ-1:0]               req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]    req_data,
  input  logic [N_REQ*DATA_WIDTH/8-1:0]  req_byte_en,
  input  logic [N_REQ-1:0]               req_last,
  output logic [N_REQ-1:0]               req_ready,
  output logic [ADDR_WIDTH-1:0]          addr,
  output logic [DATA_WIDTH-1:0]          data,
  output logic [DATA_WIDTH/8-1:0]        byte_en,
  output logic                           write_en,
  output logic [$clog2(N_REQ)-1:0]       grant_id,
  output logic                           busy
`ifdef VMON_MSG_ARB_TIMEOUT_EN
  ,
  output logic                           timeout_pulse
`endif
);

  localparam int GW = $clog2(N_REQ);
  localparam int BW = DATA_WIDTH / 8;

  arb_state_e      state_q, state_d;
  logic [GW-1:0]   grant_id_q, grant_id_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [BW-1:0]   byte_en_q, byte_en_d;
  logic            write_en_q, write_en_d;
  logic            ptr_upd;
  logic [GW-1:0]   rr_sel;
  logic            rr_any;
  logic            accept;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [BW-1:0]   cur_be;
  logic            cur_last;

`ifdef VMON_MSG_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tmo_q, tmo_d;
`else
  logic            unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  vmon_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk         (clk),
    .reset       (reset),
    .valid_i     (req_valid),
    .update_i    (ptr_upd),
    .update_id_i (grant_id_q),
    .sel_o       (rr_sel),
    .any_o       (rr_any)
  );

  // Grantee's current beat and the handshake, decoded from registered state.
  always_comb begin
    cur_data  = req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
    cur_be    = req_byte_en[int'(grant_id_q)*BW +: BW];
    cur_last  = req_last[grant_id_q];
    accept    = (state_q == GRANT) && req_valid[grant_id_q];
    req_ready = '0;
    if (state_q == GRANT) begin
      req_ready[grant_id_q] = 1'b1;
    end
  end

  // Next-state: arbitrate in IDLE, stream and release on last beat in GRANT.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    data_d     = data_q;
    byte_en_d  = byte_en_q;
    write_en_d = 1'b0;
    ptr_upd    = 1'b0;
`ifdef VMON_MSG_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    tmo_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (rr_any) begin
          grant_id_d = rr_sel;
          state_d    = GRANT;
`ifdef VMON_MSG_ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      GRANT: begin
        if (accept) begin
          data_d     = cur_data;
          byte_en_d  = cur_be;
          write_en_d = |cur_be;
`ifdef VMON_MSG_ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
          if (cur_last) begin
            state_d = IDLE;
            ptr_upd = 1'b1;
          end
        end
`ifdef VMON_MSG_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(TIMEOUT)) begin
            state_d = IDLE;
            ptr_upd = 1'b1;
            tmo_d   = 1'b1;
            cnt_d   = '0;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any partial message.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      data_q     <= '0;
      byte_en_q  <= '0;
      write_en_q <= 1'b0;
`ifdef VMON_MSG_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      data_q     <= data_d;
      byte_en_q  <= byte_en_d;
      write_en_q <= write_en_d;
`ifdef VMON_MSG_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign addr     = ADDR;
  assign data     = data_q;
  assign byte_en  = byte_en_q;
  assign write_en = write_en_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q == GRANT);
`ifdef VMON_MSG_ARB_TIMEOUT_EN
  assign timeout_pulse = tmo_q;
`endif

endmodule

// File: tb/tb_vmon_msg_arbiter.sv
// Scoreboard bench for vmon_msg_arbiter: directed messages push expected
// writes and grants; a negedge monitor pops and compares.
module tb_vmon_msg_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam logic [AW-1:0] MBOX = 32'h0000_1000;
  localparam int TMO = 8;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  be;
    logic        last;
    int          gap;
  } beat_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N*DW/8-1:0] req_byte_en = '0;
  logic [N-1:0]    req_last = '0;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   data;
  logic [DW/8-1:0] byte_en;
  logic            write_en;
  logic [1:0]      grant_id;
  logic            busy;
`ifdef VMON_MSG_ARB_TIMEOUT_EN
  logic            timeout_pulse;
  int              n_tmo = 0;
  int              tmo_gap = -1;
`endif

  int    n_vec = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    last_wr_cyc = 0;
  logic  stall_chk = 1'b0;

  beat_t bq [N][$];
  wr_t   exp_w[$];
  int    exp_g[$];

  vmon_msg_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR(MBOX), .TIMEOUT(TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_byte_en (req_byte_en),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .addr        (addr),
    .data        (data),
    .byte_en     (byte_en),
    .write_en    (write_en),
    .grant_id    (grant_id),
    .busy        (busy)
`ifdef VMON_MSG_ARB_TIMEOUT_EN
    ,
    .timeout_pulse (timeout_pulse)
`endif
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one line per observed write or grant.
  initial begin : monitor
    logic busy_prev;
    wr_t  w;
    int   g;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (write_en) begin
          last_wr_cyc = cyc;
          if (exp_w.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_write: got data 0x%0h be 0x%0h, expected no write", data, byte_en);
          end else begin
            w = exp_w.pop_front();
            $display("write  data=0x%08h be=0x%0h addr=0x%0h", data, byte_en, addr);
            check("write_data", data, w.d);
            check("write_be", byte_en, w.be);
            check("write_addr", addr, MBOX);
          end
        end
        if (busy && !busy_prev) begin
          if (exp_g.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_grant: got grant %0d, expected none", grant_id);
          end else begin
            g = exp_g.pop_front();
            $display("grant  id=%0d", grant_id);
            check("grant_id", grant_id, g);
          end
        end
`ifdef VMON_MSG_ARB_TIMEOUT_EN
        if (timeout_pulse) begin
          n_tmo++;
          tmo_gap = cyc - last_wr_cyc;
          $display("timeout pulse after %0d cycles", tmo_gap);
        end
`endif
      end
      busy_prev = busy;
    end
  end

  task automatic send(input int r, input logic [31:0] d, input logic [3:0] be,
                      input logic last, input int gap);
    beat_t b;
    b.d = d; b.be = be; b.last = last; b.gap = gap;
    bq[r].push_back(b);
  endtask

  task automatic expw(input logic [31:0] d, input logic [3:0] be);
    wr_t w;
    w.d = d; w.be = be;
    exp_w.push_back(w);
  endtask

  // Present each requester's head beat, honouring its pre-beat gap.
  task automatic drive();
    beat_t h;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0;
      req_data[i*DW +: DW] = '0;
      req_byte_en[i*4 +: 4] = '0;
      req_last[i] = 1'b0;
      if (bq[i].size() > 0) begin
        h = bq[i][0];
        if (h.gap > 0) begin
          h.gap--;
          bq[i][0] = h;
        end else begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = h.d;
          req_byte_en[i*4 +: 4] = h.be;
          req_last[i] = h.last;
        end
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    if (stall_chk && bq[1].size() > 0) check("stall_ready3", req_ready[3], 1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) void'(bq[i].pop_front());
    drive();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (bq[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run(input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(all_empty() && !busy && exp_w.size() == 0 && exp_g.size() == 0) && n < 300);
    step();
    step();
    if (n >= 300) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s_budget: got %0d cycles without completion, expected under 300", name, n);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_write_en"}, write_en, 1'b0);
    check({tag, "_data"}, data, 32'h0);
    check({tag, "_byte_en"}, byte_en, 4'h0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_grant_id"}, grant_id, 2'd0);
    check({tag, "_req_ready"}, req_ready, 4'h0);
`ifdef VMON_MSG_ARB_TIMEOUT_EN
    check({tag, "_timeout_pulse"}, timeout_pulse, 1'b0);
`endif
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    for (int i = 0; i < N; i++) bq[i].delete();
    exp_w.delete();
    exp_g.delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : stim
    int n;
    do_reset("rst0");

    // Single requester, two-beat message.
    send(2, 32'h1122_3344, 4'hF, 1'b0, 0);
    send(2, 32'h0000_00AA, 4'h1, 1'b1, 0);
    exp_g.push_back(2);
    expw(32'h1122_3344, 4'hF);
    expw(32'h0000_00AA, 4'h1);
    run("single");

    // Four simultaneous one-beat messages after reset: 0,1,2,3.
    do_reset("rst1");
    for (int i = 0; i < N; i++) begin
      send(i, 32'hA0A0_0000 + 32'(i), 4'hF, 1'b1, 0);
      exp_g.push_back(i);
      expw(32'hA0A0_0000 + 32'(i), 4'hF);
    end
    run("all4");

    // Requester 0 granted again, then 0,1,2 together: 1,2,0.
    send(0, 32'hB000_0000, 4'h3, 1'b1, 0);
    exp_g.push_back(0);
    expw(32'hB000_0000, 4'h3);
    run("r0_again");
    send(0, 32'hC000_0000, 4'hF, 1'b1, 0);
    send(1, 32'hC000_0001, 4'hF, 1'b1, 0);
    send(2, 32'hC000_0002, 4'hF, 1'b1, 0);
    exp_g.push_back(1); expw(32'hC000_0001, 4'hF);
    exp_g.push_back(2); expw(32'hC000_0002, 4'hF);
    exp_g.push_back(0); expw(32'hC000_0000, 4'hF);
    run("fair");

    // Grantee 1 stalls 5 cycles mid-message; requester 3 must wait.
    stall_chk = 1'b1;
    send(1, 32'h1111_0001, 4'hF, 1'b0, 0);
    send(1, 32'h1111_0002, 4'hC, 1'b1, 5);
    send(3, 32'h3333_0003, 4'hF, 1'b1, 0);
    exp_g.push_back(1); expw(32'h1111_0001, 4'hF); expw(32'h1111_0002, 4'hC);
    exp_g.push_back(3); expw(32'h3333_0003, 4'hF);
    run("stall");
    stall_chk = 1'b0;

    // Zero byte-enable last beat: no write, pointer moves to 2 so 3 beats 2.
    send(2, 32'hDEAD_BEEF, 4'h0, 1'b1, 0);
    exp_g.push_back(2);
    run("zero_be");
    send(2, 32'hE000_0002, 4'hF, 1'b1, 0);
    send(3, 32'hE000_0003, 4'hF, 1'b1, 0);
    exp_g.push_back(3); expw(32'hE000_0003, 4'hF);
    exp_g.push_back(2); expw(32'hE000_0002, 4'hF);
    run("ptr_adv");

    // Reset after beat 1 of 3.
    send(1, 32'h5555_0001, 4'hF, 1'b0, 0);
    send(1, 32'h5555_0002, 4'hF, 1'b0, 4);
    send(1, 32'h5555_0003, 4'hF, 1'b1, 0);
    exp_g.push_back(1);
    expw(32'h5555_0001, 4'hF);
    n = 0;
    while (bq[1].size() == 3 && n < 50) begin
      step();
      n++;
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    check("rst_mid_pending_writes", exp_w.size(), 0);
    for (int i = 0; i < N; i++) bq[i].delete();
    exp_g.delete();
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    send(0, 32'h6000_0000, 4'hF, 1'b1, 0);
    send(3, 32'h6000_0003, 4'hF, 1'b1, 0);
    exp_g.push_back(0); expw(32'h6000_0000, 4'hF);
    exp_g.push_back(3); expw(32'h6000_0003, 4'hF);
    run("after_rst");

`ifdef VMON_MSG_ARB_TIMEOUT_EN
    // Grantee 0 stalls forever after one beat; forced release, then 1.
    send(0, 32'h7000_0000, 4'hF, 1'b0, 0);
    send(1, 32'h7000_0001, 4'hF, 1'b1, 0);
    exp_g.push_back(0); expw(32'h7000_0000, 4'hF);
    exp_g.push_back(1); expw(32'h7000_0001, 4'hF);
    run("timeout");
    check("timeout_count", n_tmo, 1);
    check("timeout_gap", tmo_gap, TMO);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/vmon_msg_arbiter.md
# vmon_msg_arbiter

Shares one monitored mailbox write port among N message requesters. Each requester presents a framed byte-enabled message stream. The arbiter grants one requester at a time in round-robin order and holds the grant until that message's last beat. It then replays the accepted beats as registered single-cycle writes to address ADDR, and these drive the clk/reset/addr/data/byte_en/write_en inputs of vmon_bus_monitor.

## Interface
Parameters:
- N_REQ, 4: number of requesters (2..16)
- ADDR_WIDTH, 32: output address width
- DATA_WIDTH, 32: beat width; multiple of 8, maximum 64
- ADDR, 0: mailbox address driven on every write
- TIMEOUT, 256: idle-beat cycles before a forced release; used only with VMON_MSG_ARB_TIMEOUT_EN

Ports:
- clk  in  1  the block's single clock
- reset  in  1  asynchronous, active-high
- req_valid  in  N_REQ  per-requester beat valid
- req_data  in  N_REQ*DATA_WIDTH  beat data; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]
- req_byte_en  in  N_REQ*DATA_WIDTH/8  beat byte enables, packed the same way
- req_last  in  N_REQ  last beat of the message
- req_ready  out  N_REQ  beat accepted when valid & ready
- addr  out  ADDR_WIDTH  always ADDR
- data  out  DATA_WIDTH  registered write data
- byte_en  out  DATA_WIDTH/8  registered byte enables
- write_en  out  1  single-cycle write strobe
- grant_id  out  $clog2(N_REQ)  current or most recent grantee
- busy  out  1  high while in GRANT
- timeout_pulse  out  1  forced-release indication; present only with VMON_MSG_ARB_TIMEOUT_EN

## Operation
- Two-state FSM: IDLE and GRANT.
- IDLE:
  - If any req_valid is high, select the first valid requester scanning upward from ptr+1, wrapping modulo N_REQ.
  - Register grant_id, then move to GRANT.
  - All req_ready are 0.
- GRANT:
  - req_ready[grant_id] = 1; all other req_ready = 0.
  - Each accepted beat is copied to data/byte_en, with write_en = 1 on the next cycle.
  - A beat with byte_en == 0 is accepted but produces no write_en. It still counts for req_last.
  - An accepted beat with req_last = 1 returns the FSM to IDLE and sets ptr = grant_id.
- Lock rule: the grant is held while the grantee deasserts req_valid mid-message. Other requesters wait.
- Fairness: after a grant to requester i, requester i has the lowest priority in the next arbitration.
- Reset values:
  - write_en = 0, data = 0, byte_en = 0, busy = 0, grant_id = 0, timeout_pulse = 0.
  - ptr = N_REQ-1, so requester 0 wins first.
- Reset mid-message:
  - The partial message is abandoned. No write_en is issued after reset asserts.
  - The FSM restarts in IDLE.
- req_ready is a combinational decode of state and grant_id only. It never depends on req_valid.

## Timing
- Arbitration cycle: valid seen in IDLE at cycle t, so busy = 1 and req_ready = 1 at t+1.
- Beat latency: beat accepted at cycle t, so write_en/data/byte_en appear at t+1 for exactly one cycle.
- Throughput: one beat per cycle while the grantee streams. There is one dead cycle (IDLE) between messages.
  - Example: a one-beat message takes 2 cycles end to end.
- Last-beat cycle: busy falls at t+1, and the next arbitration happens at t+1.
- Simultaneous requests: all requesters asserting in the same IDLE cycle are resolved in that one cycle by the round-robin scan.
- Outputs change only on posedge clk or on asynchronous reset.

## Configuration
- VMON_MSG_ARB_TIMEOUT_EN defined:
  - A counter clears on every accepted beat and on entry to GRANT, and increments each GRANT cycle with no accepted beat.
  - When the counter reaches TIMEOUT:
    - force IDLE;
    - set ptr = grant_id;
    - pulse timeout_pulse high for 1 cycle;
    - issue no write.
  - The counter width is $clog2(TIMEOUT+1).
- VMON_MSG_ARB_TIMEOUT_EN undefined:
  - There is no counter and no timeout_pulse port.
  - A stalled grantee holds the grant indefinitely.

## Structure
- Package vmon_msg_arb_pkg contains:
  - the state enum (IDLE, GRANT);
  - the function rr_next(valid, ptr), which returns the winning index.
- Sub-module vmon_rr_arbiter holds the round-robin pointer and select logic. It has a pointer-update strobe input.
- The top level holds the FSM, the lock, the output registers and the timeout counter.

## Test plan
- Reset then single requester:
  - Stimulus: N_REQ=4; requester 2 sends beats 0x11223344 (byte_en 0xF) and 0x000000AA (byte_en 0x1, last).
  - Response: two write_en pulses with exactly that data/byte_en at ADDR, and grant_id = 2.
- All four requesters each hold a one-beat message simultaneously:
  - Response: grants in the order 0,1,2,3.
  - Then requester 0 re-requests while 1 and 2 also request: order 1, 2, 0.
- Mid-message stall:
  - Stimulus: requester 1 drops req_valid for 5 cycles between beats while requester 3 is valid.
  - Response: requester 3 gets no req_ready until requester 1's last beat completes.
- Zero byte_en beat:
  - Stimulus: beat with byte_en 0x0 and last = 1.
  - Response: no write_en, FSM returns to IDLE, ptr advances.
- Reset mid-message:
  - Stimulus: assert reset after beat 1 of 3.
  - Response: all outputs reach their reset values immediately, no further writes, and requester 0 wins after release.
- With VMON_MSG_ARB_TIMEOUT_EN and TIMEOUT=8:
  - Stimulus: the grantee stalls.
  - Response: timeout_pulse after 8 idle GRANT cycles, then the next requester is granted.
